// File: rtl/cpu_datapath.sv
// Register/bus/ALU datapath of the 8-bit CPU. Registers update one edge after the control word;
// bus, ALU and memory strobes are combinational. No backpressure: the controller owns all sequencing.
module cpu_datapath (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] ctrl,
   input  logic [7:0]  mem_rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  opcode,
   output logic        z_flag,
   output logic [7:0]  ac_out,
   output logic [15:0] pc_out
);

   localparam int RLOAD  = 19;
   localparam int TRLOAD = 18;
   localparam int ARLOAD = 17;
   localparam int ARINC  = 16;
   localparam int PCLOAD = 15;
   localparam int PCINC  = 14;
   localparam int DRLOAD = 13;
   localparam int ACLOAD = 12;
   localparam int IRLOAD = 11;
   localparam int ZLOAD  = 10;
   localparam int MEMBUS = 9;
   localparam int BUSMEM = 8;
   localparam int PCBUS  = 7;
   localparam int DRHBUS = 6;
   localparam int DRLBUS = 5;
   localparam int TRBUS  = 4;
   localparam int RBUS   = 3;
   localparam int ACBUS  = 2;
   localparam int READ   = 1;
   localparam int WRITE  = 0;

   logic [15:0] ar_q, ar_d, pc_q, pc_d;
   logic [7:0]  dr_q, dr_d, tr_q, tr_d, ir_q, ir_d, r_q, r_d, ac_q, ac_d;
   logic        z_q, z_d;
   logic [15:0] bus;
   logic [7:0]  alu_res;
   logic [3:0]  alu_op;

   assign alu_op = ctrl[23:20];

   // Wired-OR bus: DRHBUS+TRBUS is how {DR,TR} forms a 16-bit address.
   assign bus = ({16{ctrl[PCBUS]}}                 & pc_q)
              | ({16{ctrl[DRHBUS]}}                & {dr_q, 8'h00})
              | ({16{ctrl[DRLBUS]}}                & {8'h00, dr_q})
              | ({16{ctrl[TRBUS]}}                 & {8'h00, tr_q})
              | ({16{ctrl[RBUS]}}                  & {8'h00, r_q})
              | ({16{ctrl[ACBUS]}}                 & {8'h00, ac_q})
              | ({16{ctrl[MEMBUS] & ctrl[READ]}}   & {8'h00, mem_rdata});

   always_comb begin
      alu_res = bus[7:0];
      case (alu_op)
         4'b0001: alu_res = ac_q + bus[7:0];
         4'b0010: alu_res = ac_q - bus[7:0];
         4'b0011: alu_res = ac_q + 8'd1;
         4'b0100: alu_res = 8'h00;
         4'b0101: alu_res = ac_q & bus[7:0];
         4'b0110: alu_res = ac_q | bus[7:0];
         4'b0111: alu_res = ac_q ^ bus[7:0];
         4'b1000: alu_res = ~ac_q;
         default: alu_res = bus[7:0];
      endcase
   end

   always_comb begin
      ar_d = ar_q;
      pc_d = pc_q;
      dr_d = dr_q;
      tr_d = tr_q;
      ir_d = ir_q;
      r_d  = r_q;
      ac_d = ac_q;
      z_d  = z_q;
      if (ctrl[ARLOAD])      ar_d = bus;
      else if (ctrl[ARINC])  ar_d = ar_q + 16'd1;
      if (ctrl[PCLOAD])      pc_d = bus;
      else if (ctrl[PCINC])  pc_d = pc_q + 16'd1;
      if (ctrl[DRLOAD])      dr_d = bus[7:0];
      // IR, TR and R load over dedicated paths from the pre-edge register values.
      if (ctrl[IRLOAD])      ir_d = dr_q;
      if (ctrl[TRLOAD])      tr_d = dr_q;
      if (ctrl[RLOAD])       r_d  = ac_q;
      if (ctrl[ACLOAD])      ac_d = alu_res;
      if (ctrl[ACLOAD] || ctrl[ZLOAD]) z_d = (alu_res == 8'h00);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar_q <= 16'h0000;
         pc_q <= 16'h0000;
         dr_q <= 8'h00;
         tr_q <= 8'h00;
         ir_q <= 8'h00;
         r_q  <= 8'h00;
         ac_q <= 8'h00;
         z_q  <= 1'b0;
      end else begin
         ar_q <= ar_d;
         pc_q <= pc_d;
         dr_q <= dr_d;
         tr_q <= tr_d;
         ir_q <= ir_d;
         r_q  <= r_d;
         ac_q <= ac_d;
         z_q  <= z_d;
      end
   end

   assign mem_addr  = ar_q;
   assign mem_wdata = bus[7:0];
   assign mem_rd    = ctrl[READ];
   assign mem_wr    = ctrl[WRITE] & ctrl[BUSMEM];
   assign opcode    = ir_q;
   assign z_flag    = z_q;
   assign ac_out    = ac_q;
   assign pc_out    = pc_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: small ROM model, write capture, hand-computed expectations.
module tb_cpu_datapath;

   localparam logic [23:0] RLOAD  = 24'd1 << 19;
   localparam logic [23:0] TRLOAD = 24'd1 << 18;
   localparam logic [23:0] ARLOAD = 24'd1 << 17;
   localparam logic [23:0] ARINC  = 24'd1 << 16;
   localparam logic [23:0] PCLOAD = 24'd1 << 15;
   localparam logic [23:0] PCINC  = 24'd1 << 14;
   localparam logic [23:0] DRLOAD = 24'd1 << 13;
   localparam logic [23:0] ACLOAD = 24'd1 << 12;
   localparam logic [23:0] IRLOAD = 24'd1 << 11;
   localparam logic [23:0] ZLOAD  = 24'd1 << 10;
   localparam logic [23:0] MEMBUS = 24'd1 << 9;
   localparam logic [23:0] BUSMEM = 24'd1 << 8;
   localparam logic [23:0] PCBUS  = 24'd1 << 7;
   localparam logic [23:0] DRHBUS = 24'd1 << 6;
   localparam logic [23:0] DRLBUS = 24'd1 << 5;
   localparam logic [23:0] TRBUS  = 24'd1 << 4;
   localparam logic [23:0] RBUS   = 24'd1 << 3;
   localparam logic [23:0] ACBUS  = 24'd1 << 2;
   localparam logic [23:0] READ   = 24'd1 << 1;
   localparam logic [23:0] WRITE  = 24'd1;
   localparam logic [23:0] OP_ADD = 24'h100000;
   localparam logic [23:0] OP_SUB = 24'h200000;
   localparam logic [23:0] OP_INC = 24'h300000;
   localparam logic [23:0] OP_CLR = 24'h400000;
   localparam logic [23:0] OP_NOT = 24'h800000;
   localparam logic [23:0] RDMEM  = READ | MEMBUS | DRLOAD;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] ctrl = 24'h0;
   logic [7:0]  mem_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_rd, mem_wr;
   logic [7:0]  opcode;
   logic        z_flag;
   logic [7:0]  ac_out;
   logic [15:0] pc_out;

   int          n_chk = 0;
   int          n_fail = 0;
   int          wr_cnt = 0;
   logic [15:0] wr_addr = 16'h0;
   logic [7:0]  wr_dat = 8'h0;

   cpu_datapath dut (
      .clk(clk), .rst(rst), .ctrl(ctrl), .mem_rdata(mem_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .opcode(opcode), .z_flag(z_flag), .ac_out(ac_out), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom(input logic [15:0] a);
      case (a)
         16'h0000: rom = 8'h08;
         16'h0001: rom = 8'h34;
         16'h0002: rom = 8'h12;
         16'h1234: rom = 8'h5A;
         16'h1235: rom = 8'hC3;
         16'h1236: rom = 8'h12;
         16'h1237: rom = 8'h0F;
         16'h1238: rom = 8'h42;
         16'h0042: rom = 8'hFF;
         default:  rom = 8'h00;
      endcase
   endfunction

   assign mem_rdata = rom(mem_addr);

   always @(posedge clk) begin
      if (mem_wr) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= mem_addr;
         wr_dat  <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [23:0] c);
      ctrl = c;
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [23:0] c);
      ctrl = c;
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pc"},   pc_out,   16'h0000);
      chk({tag, "_addr"}, mem_addr, 16'h0000);
      chk({tag, "_ac"},   {8'h00, ac_out}, 16'h0000);
      chk({tag, "_op"},   {8'h00, opcode}, 16'h0000);
      chk({tag, "_z"},    {15'h0, z_flag}, 16'h0000);
   endtask

   initial begin
      // Reset with random control word, including an edge while held
      #1;
      rst  = 1'b1;
      ctrl = 24'($urandom);
      #1;
      chk_all_zero("rst");
      @(posedge clk);
      #1;
      chk_all_zero("rst_edge");
      ctrl = 24'h0;
      #2;
      rst = 1'b0;

      // Fetch
      step(PCBUS | ARLOAD);
      peek(RDMEM | PCINC);
      chk("fetch_rd", {15'h0, mem_rd}, 16'h0001);
      chk("fetch_wdata", {8'h00, mem_wdata}, 16'h0008);
      step(RDMEM | PCINC);
      step(IRLOAD | PCBUS | ARLOAD);
      chk("fetch_op", {8'h00, opcode}, 16'h0008);
      chk("fetch_pc", pc_out, 16'h0001);
      chk("fetch_addr", mem_addr, 16'h0001);

      // LDAC
      step(RDMEM | PCINC | ARINC);
      step(TRLOAD | RDMEM | PCINC | ARINC);
      step(DRHBUS | TRBUS | ARLOAD);
      chk("ldac_addr", mem_addr, 16'h1234);
      step(RDMEM);
      step(DRLBUS | ACLOAD);
      chk("ldac_ac", {8'h00, ac_out}, 16'h005A);
      chk("ldac_z", {15'h0, z_flag}, 16'h0000);
      chk("ldac_pc", pc_out, 16'h0003);
      peek(TRBUS);
      chk("ldac_tr", {8'h00, mem_wdata}, 16'h0034);

      // STAC prep: AC=C3, AR back to 1234
      step(ARINC);
      step(RDMEM | ARINC);
      step(DRLBUS | ACLOAD);
      step(RDMEM);
      step(DRHBUS | TRBUS | ARLOAD);
      chk("stac_ac", {8'h00, ac_out}, 16'h00C3);
      peek(WRITE);
      chk("wr_nobusmem", {15'h0, mem_wr}, 16'h0000);
      peek(ACBUS | BUSMEM | WRITE);
      chk("stac_wr", {15'h0, mem_wr}, 16'h0001);
      chk("stac_addr", mem_addr, 16'h1234);
      chk("stac_wdata", {8'h00, mem_wdata}, 16'h00C3);
      step(ACBUS | BUSMEM | WRITE);
      step(24'h0);
      chk("stac_cnt", 16'(wr_cnt), 16'h0001);
      chk("stac_cap_addr", wr_addr, 16'h1234);
      chk("stac_cap_dat", {8'h00, wr_dat}, 16'h00C3);

      // ALU / Z
      step(OP_CLR | ACLOAD);
      chk("clac_ac", {8'h00, ac_out}, 16'h0000);
      chk("clac_z", {15'h0, z_flag}, 16'h0001);
      step(OP_INC | ACLOAD);
      step(RLOAD);
      step(OP_CLR | ACLOAD);
      step(OP_NOT | ACLOAD);
      chk("not_ff", {8'h00, ac_out}, 16'h00FF);
      step(OP_ADD | RBUS | ACLOAD);
      chk("add_ac", {8'h00, ac_out}, 16'h0000);
      chk("add_z", {15'h0, z_flag}, 16'h0001);
      step(OP_SUB | RBUS | ACLOAD);
      chk("sub_ac", {8'h00, ac_out}, 16'h00FF);
      chk("sub_z", {15'h0, z_flag}, 16'h0000);
      step(OP_INC | ACLOAD);
      chk("inac_ac", {8'h00, ac_out}, 16'h0000);
      chk("inac_z", {15'h0, z_flag}, 16'h0001);

      // AC=0F, R=0F, NOT -> F0, OR-bus
      for (int i = 0; i < 3; i++) step(ARINC);
      step(RDMEM | ARINC);
      step(DRLBUS | ACLOAD);
      step(RLOAD);
      step(OP_NOT | ACLOAD);
      chk("not_f0", {8'h00, ac_out}, 16'h00F0);
      chk("not_z", {15'h0, z_flag}, 16'h0000);
      peek(RBUS | ACBUS);
      chk("bus_or", {8'h00, mem_wdata}, 16'h00FF);
      step(ZLOAD);
      chk("zload_z", {15'h0, z_flag}, 16'h0001);
      chk("zload_ac", {8'h00, ac_out}, 16'h00F0);
      step(OP_INC | ACLOAD | RLOAD);
      chk("r_ac_ac", {8'h00, ac_out}, 16'h00F1);
      peek(RBUS);
      chk("r_ac_r", {8'h00, mem_wdata}, 16'h00F0);

      // Priority and wrap
      step(RDMEM);
      step(DRLBUS | ARLOAD | ARINC | PCLOAD | PCINC);
      chk("prio_ar", mem_addr, 16'h0042);
      chk("prio_pc", pc_out, 16'h0042);
      step(RDMEM);
      step(TRLOAD);
      step(DRHBUS | TRBUS | PCLOAD | ARLOAD);
      chk("ffff_pc", pc_out, 16'hFFFF);
      chk("ffff_ar", mem_addr, 16'hFFFF);
      step(PCINC | ARINC);
      chk("wrap_pc", pc_out, 16'h0000);
      chk("wrap_ar", mem_addr, 16'h0000);
      step(RDMEM | IRLOAD);
      chk("ir_old_dr", {8'h00, opcode}, 16'h00FF);
      step(IRLOAD);
      chk("ir_new_dr", {8'h00, opcode}, 16'h0008);

      // Reset mid-LDAC, held across an edge with active control
      ctrl = RDMEM | PCINC | ARINC | OP_INC | ACLOAD | IRLOAD;
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      @(posedge clk);
      #1;
      chk_all_zero("midrst_edge");
      #2;
      rst = 1'b0;
      step(PCINC | OP_INC | ACLOAD);
      chk("post_rst_pc", pc_out, 16'h0001);
      chk("post_rst_ac", {8'h00, ac_out}, 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
